// File: rtl/sram_byte_ctrl.sv
// rtl/sram_byte_ctrl.sv - byte-wide request controller for a bit-addressed dual-read-port SRAM
module sram_byte_ctrl #(
   parameter bit WR_ACK = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [8:0]  req_addr,
   input  logic [7:0]  req_wdata,
   output logic        resp_valid,
   output logic [7:0]  resp_rdata,
   output logic [11:0] mem_addr1,
   output logic [11:0] mem_addr2,
   output logic        mem_wbit,
   output logic        mem_rdwr,
   output logic        mem_deven,
   input  logic        mem_rbit1,
   input  logic        mem_rbit2
);

   typedef enum logic [2:0] {IDLE, RD, WR, DRAIN, RESP} state_t;

   state_t      state_q, state_d;
   logic [2:0]  beat_q, beat_d;       // beat currently in its address stage
   logic [1:0]  acc_k_q, acc_k_d;     // read beat currently in its access stage
   logic [8:0]  addr_q, addr_d;
   logic        we_q, we_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  rbuf_q, rbuf_d;

   logic        ready_q, ready_d;
   logic        resp_valid_q, resp_valid_d;
   logic [7:0]  resp_rdata_q, resp_rdata_d;
   logic [11:0] addr1_q, addr1_d;
   logic [11:0] addr2_q, addr2_d;
   logic        wbit_q, wbit_d;
   logic        rdwr_q, rdwr_d;
   logic        deven_q, deven_d;

   // address-stage drive request for the beat that follows
   logic        drv;
   logic [8:0]  drv_a;
   logic        drv_we;
   logic [7:0]  drv_wd;
   logic [2:0]  drv_k;

   // next-state, pipeline stage outputs and read-bit capture
   always_comb begin
      state_d      = state_q;
      beat_d       = beat_q;
      acc_k_d      = acc_k_q;
      addr_d       = addr_q;
      we_d         = we_q;
      wdata_d      = wdata_q;
      rbuf_d       = rbuf_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      addr1_d      = 12'd0;
      addr2_d      = 12'd0;
      wbit_d       = 1'b0;
      rdwr_d       = 1'b0;
      deven_d      = 1'b1;
      drv          = 1'b0;
      drv_a        = addr_q;
      drv_we       = we_q;
      drv_wd       = wdata_q;
      drv_k        = 3'd0;

      // a read access stage ends at this edge: store both read lines
      if (!deven_q && !rdwr_q) begin
         rbuf_d[{acc_k_q, 1'b0}] = mem_rbit1;
         rbuf_d[{acc_k_q, 1'b1}] = mem_rbit2;
      end

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               we_d    = req_we;
               wdata_d = req_wdata;
               rbuf_d  = 8'd0;
               beat_d  = 3'd0;
               state_d = req_we ? WR : RD;
               drv     = 1'b1;
               drv_a   = req_addr;
               drv_we  = req_we;
               drv_wd  = req_wdata;
               drv_k   = 3'd0;
            end
         end
         RD, WR: begin
            // previous address stage becomes this cycle's access stage
            deven_d = 1'b0;
            rdwr_d  = we_q;
            acc_k_d = beat_q[1:0];
            if (beat_q == (we_q ? 3'd7 : 3'd3)) begin
               state_d = DRAIN;
            end else begin
               beat_d = beat_q + 3'd1;
               drv    = 1'b1;
               drv_k  = beat_q + 3'd1;
            end
         end
         DRAIN: begin
            if (!we_q) begin
               resp_valid_d = 1'b1;
               resp_rdata_d = rbuf_d;
               state_d      = RESP;
            end else if (WR_ACK) begin
               resp_valid_d = 1'b1;
               resp_rdata_d = 8'd0;
               state_d      = RESP;
            end else begin
               state_d = IDLE;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // writes use one bit per beat on both ports; reads fetch two bits per beat
      if (drv) begin
         if (drv_we) begin
            addr1_d = {drv_a, drv_k};
            addr2_d = {drv_a, drv_k};
            wbit_d  = drv_wd[drv_k];
         end else begin
            addr1_d = {drv_a, drv_k[1:0], 1'b0};
            addr2_d = {drv_a, drv_k[1:0], 1'b1};
         end
      end

      ready_d = (state_d == IDLE);
   end

   // state and registered outputs, synchronous reset aborts any operation
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         beat_q       <= 3'd0;
         acc_k_q      <= 2'd0;
         addr_q       <= 9'd0;
         we_q         <= 1'b0;
         wdata_q      <= 8'd0;
         rbuf_q       <= 8'd0;
         ready_q      <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 8'd0;
         addr1_q      <= 12'd0;
         addr2_q      <= 12'd0;
         wbit_q       <= 1'b0;
         rdwr_q       <= 1'b0;
         deven_q      <= 1'b1;
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         acc_k_q      <= acc_k_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
         rbuf_q       <= rbuf_d;
         ready_q      <= ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         addr1_q      <= addr1_d;
         addr2_q      <= addr2_d;
         wbit_q       <= wbit_d;
         rdwr_q       <= rdwr_d;
         deven_q      <= deven_d;
      end
   end

   assign req_ready  = ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign mem_addr1  = addr1_q;
   assign mem_addr2  = addr2_q;
   assign mem_wbit   = wbit_q;
   assign mem_rdwr   = rdwr_q;
   assign mem_deven  = deven_q;

endmodule

// File: tb/tb_sram_byte_ctrl.sv
// tb/tb_sram_byte_ctrl.sv - self-checking bench for sram_byte_ctrl with a bit-cell SRAM model
module tb_sram_byte_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid [2];
   logic        req_we    [2];
   logic [8:0]  req_addr  [2];
   logic [7:0]  req_wdata [2];
   logic        req_ready [2];
   logic        resp_valid[2];
   logic [7:0]  resp_rdata[2];
   logic [11:0] maddr1    [2];
   logic [11:0] maddr2    [2];
   logic        mwbit     [2];
   logic        mrdwr     [2];
   logic        mdeven    [2];
   logic        rbit1     [2];
   logic        rbit2     [2];

   // index 0: writes acknowledged, index 1: silent writes
   sram_byte_ctrl #(.WR_ACK(1'b1)) dut_ack (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
      .mem_addr1(maddr1[0]), .mem_addr2(maddr2[0]), .mem_wbit(mwbit[0]),
      .mem_rdwr(mrdwr[0]), .mem_deven(mdeven[0]),
      .mem_rbit1(rbit1[0]), .mem_rbit2(rbit2[0])
   );

   sram_byte_ctrl #(.WR_ACK(1'b0)) dut_nack (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
      .mem_addr1(maddr1[1]), .mem_addr2(maddr2[1]), .mem_wbit(mwbit[1]),
      .mem_rdwr(mrdwr[1]), .mem_deven(mdeven[1]),
      .mem_rbit1(rbit1[1]), .mem_rbit2(rbit2[1])
   );

   always #5 clk = ~clk;

   // SRAM bit-cell model: latches address/wbit one edge after they are driven
   logic        mem_m [2][4096];
   logic [11:0] lat1  [2];
   logic [11:0] lat2  [2];
   logic        latw  [2];
   logic        init_mem;

   always @(posedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (init_mem) begin
            for (int i = 0; i < 4096; i++) mem_m[u][12'(i)] <= 1'b0;
         end else if (!mdeven[u] && mrdwr[u]) begin
            mem_m[u][lat1[u]] <= latw[u];
         end
         lat1[u] <= maddr1[u];
         lat2[u] <= maddr2[u];
         latw[u] <= mwbit[u];
      end
   end

   always_comb begin
      for (int u = 0; u < 2; u++) begin
         rbit1[u] = 1'b0;
         rbit2[u] = 1'b0;
         if (!mdeven[u] && !mrdwr[u]) begin
            rbit1[u] = mem_m[u][lat1[u]];
            rbit2[u] = mem_m[u][lat2[u]];
         end
      end
   end

   // reference state at byte level
   logic [7:0] ref_mem [2][512];
   logic [7:0] last_rd [2];
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      bit         we;
      logic [8:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rd;
   } vec_t;
   vec_t tbl [11];

   task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [36:0] outs(input int u);
      return {req_ready[u], maddr1[u], maddr2[u], mwbit[u], mrdwr[u], mdeven[u],
              resp_valid[u], resp_rdata[u]};
   endfunction

   function automatic logic [36:0] mk(input logic rdy, input logic [11:0] a1, input logic [11:0] a2,
                                      input logic wb, input logic rw, input logic dv,
                                      input logic rv, input logic [7:0] rd);
      return {rdy, a1, a2, wb, rw, dv, rv, rd};
   endfunction

   // one full transaction, every cycle compared against the timing rules
   task automatic run_op(input int u, input bit we, input logic [8:0] a, input logic [7:0] wd,
                         input logic [7:0] exp_rd, input bit hold);
      int n;
      int last;
      logic [11:0] e1, e2;
      logic ew, erw, edv, erv, erdy;
      logic [7:0] erd;
      req_valid[u] = 1'b1;
      req_we[u]    = we;
      req_addr[u]  = a;
      req_wdata[u] = wd;
      n = 0;
      while (req_ready[u] !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         check("accept_timeout", 37'(req_ready[u]), 37'd1);
         req_valid[u] = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      if (hold) begin
         req_we[u]    = ~we;
         req_addr[u]  = ~a;
         req_wdata[u] = ~wd;
      end else begin
         req_valid[u] = 1'b0;
      end
      last = we ? ((u == 0) ? 11 : 10) : 7;
      for (int c = 1; c <= last; c++) begin
         if (c > 1) @(negedge clk);
         e1 = 12'd0; e2 = 12'd0; ew = 1'b0; erw = 1'b0; edv = 1'b1; erv = 1'b0;
         erd = last_rd[u];
         erdy = (c == last);
         if (!we) begin
            if (c <= 4) begin
               e1 = 12'(int'(a) * 8 + 2 * (c - 1));
               e2 = e1 + 12'd1;
            end
            if (c >= 2 && c <= 5) edv = 1'b0;
            if (c == 6) begin
               erv = 1'b1;
               erd = exp_rd;
            end
         end else begin
            if (c <= 8) begin
               e1 = 12'(int'(a) * 8 + c - 1);
               e2 = e1;
               ew = wd[3'(c - 1)];
            end
            if (c >= 2 && c <= 9) begin
               edv = 1'b0;
               erw = 1'b1;
            end
            if (u == 0 && c == 10) begin
               erv = 1'b1;
               erd = 8'd0;
            end
         end
         check($sformatf("u%0d %s a=%h c%0d", u, we ? "wr" : "rd", a, c), outs(u),
               mk(erdy, e1, e2, ew, erw, edv, erv, erd));
         if (erv) last_rd[u] = erd;
      end
      if (we) ref_mem[u][a] = wd;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit         we;
      logic [8:0] a;
      logic [7:0] wd;
      int         u;

      tbl[0]  = '{1'b1, 9'h003, 8'hA5, 8'h00};
      tbl[1]  = '{1'b0, 9'h003, 8'h00, 8'hA5};
      tbl[2]  = '{1'b0, 9'h1FF, 8'h00, 8'h00};
      tbl[3]  = '{1'b1, 9'h1FF, 8'h5A, 8'h00};
      tbl[4]  = '{1'b0, 9'h1FF, 8'h00, 8'h5A};
      tbl[5]  = '{1'b1, 9'h000, 8'hFF, 8'h00};
      tbl[6]  = '{1'b0, 9'h000, 8'h00, 8'hFF};
      tbl[7]  = '{1'b1, 9'h1FE, 8'h81, 8'h00};
      tbl[8]  = '{1'b0, 9'h1FE, 8'h00, 8'h81};
      tbl[9]  = '{1'b0, 9'h1FF, 8'h00, 8'h5A};
      tbl[10] = '{1'b0, 9'h001, 8'h00, 8'h00};

      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 512; i++) ref_mem[k][i] = 8'd0;
         last_rd[k]   = 8'd0;
         req_valid[k] = 1'b1;
         req_we[k]    = 1'b0;
         req_addr[k]  = 9'h155;
         req_wdata[k] = 8'h00;
      end
      init_mem = 1'b1;
      reset    = 1'b1;

      // requests pending during reset must not be taken
      @(negedge clk);
      @(negedge clk);
      init_mem = 1'b0;
      for (int k = 0; k < 2; k++)
         check($sformatf("reset_vals u%0d", k), outs(k), mk(1, 0, 0, 0, 0, 1, 0, 8'd0));
      reset = 1'b0;
      req_valid[0] = 1'b0;
      req_valid[1] = 1'b0;

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++)
            check($sformatf("idle u%0d c%0d", k, i), outs(k), mk(1, 0, 0, 0, 0, 1, 0, 8'd0));
      end

      for (int i = 0; i < 11; i++)
         run_op(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, 1'b0);

      // back-to-back reads with req_valid held high
      run_op(0, 1'b1, 9'h010, 8'h11, 8'h00, 1'b0);
      run_op(0, 1'b1, 9'h011, 8'h22, 8'h00, 1'b0);
      run_op(0, 1'b0, 9'h010, 8'h00, 8'h11, 1'b1);
      run_op(0, 1'b0, 9'h011, 8'h00, 8'h22, 1'b0);

      // silent-write variant
      run_op(1, 1'b1, 9'h100, 8'h3C, 8'h00, 1'b0);
      run_op(1, 1'b0, 9'h100, 8'h00, 8'h3C, 1'b0);

      // reset during C4 of a write
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b1;
      req_addr[0]  = 9'h020;
      req_wdata[0] = 8'hFF;
      @(posedge clk);
      @(negedge clk);
      req_valid[0] = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_c4_addr", {25'd0, maddr1[0]}, 37'h103);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      last_rd[0] = 8'd0;
      last_rd[1] = 8'd0;
      for (int k = 0; k < 2; k++)
         check($sformatf("abort_reset u%0d", k), outs(k), mk(1, 0, 0, 0, 0, 1, 0, 8'd0));
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check($sformatf("post_abort c%0d", i), outs(0), mk(1, 0, 0, 0, 0, 1, 0, 8'd0));
      end
      run_op(0, 1'b1, 9'h020, 8'h77, 8'h00, 1'b0);
      run_op(0, 1'b0, 9'h020, 8'h00, 8'h77, 1'b0);

      // randomized traffic against the byte-level model
      for (int i = 0; i < 40; i++) begin
         u  = (i % 5 == 4) ? 1 : 0;
         we = 1'($urandom_range(0, 1));
         a  = 9'($urandom_range(0, 511));
         wd = 8'($urandom);
         run_op(u, we, a, wd, ref_mem[u][a], 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
